// File: rtl/wb_regfile.sv
// wb_regfile: writeback-stage register file for a 5-stage pipeline.
//
// Purpose
//   Holds registers x1..x31 (x0 is hard-wired to zero and never stored).
//   It selects the writeback result, commits it on the rising clock edge
//   and counts committed writes in a saturating counter.
//
// Ports
//   CLK        clock; all state updates on its rising edge
//   RSTn       synchronous active-low reset; clears registers and counter
//   RFWEW      writeback register-file write enable
//   MtoRFSelW  result select: 1 = DMOutW, 0 = ALUOutW
//   DMOutW     data-memory read data (32 bits)
//   ALUOutW    ALU result (32 bits)
//   rtdW       destination register index (5 bits)
//   rsD, rtD   decode-stage read indices (5 bits each)
//   RD1D, RD2D combinational read data (32 bits each)
//   ResultW    selected writeback value, for forwarding (32 bits)
//   WBCount    saturating count of committed writes (CNT_W bits)
//
// Configuration
//   WB_BYPASS_EN  When defined, a read port whose index matches a pending
//                 write returns ResultW in the same cycle. When undefined,
//                 read ports return only stored contents.
module wb_regfile #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             RFWEW,
  input  logic             MtoRFSelW,
  input  logic [31:0]      DMOutW,
  input  logic [31:0]      ALUOutW,
  input  logic [4:0]       rtdW,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  output logic [31:0]      RD1D,
  output logic [31:0]      RD2D,
  output logic [31:0]      ResultW,
  output logic [CNT_W-1:0] WBCount
);

  logic [31:0]      regs_q [1:31];
  logic [31:0]      regs_d [1:31];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [31:0]      read_view [0:31];
  logic             write_req;

  // Result mux and next-state computation. A write to x0 is not a commit,
  // so it neither stores data nor bumps the counter.
  always_comb begin
    ResultW   = MtoRFSelW ? DMOutW : ALUOutW;
    write_req = RFWEW && (rtdW != 5'd0);
    count_d   = count_q;
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = regs_q[i];
      if (write_req && (rtdW == 5'(i))) begin
        regs_d[i] = ResultW;
      end
    end
    // Counter saturates at all-ones instead of wrapping.
    if (write_req && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // State registers. Reset has priority, so a write presented during reset
  // is dropped.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
      count_q <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      count_q <= count_d;
    end
  end

  // A 32-entry view with a constant zero at index 0 lets both read ports
  // use a plain index without a separate x0 special case.
  always_comb begin
    read_view[0] = 32'd0;
    for (int i = 1; i < 32; i++) begin
      read_view[i] = regs_q[i];
    end
  end

  // Read ports. Stored values are shown while RSTn is low because clearing
  // only takes effect at the edge. The bypass is therefore gated by RSTn.
  always_comb begin
    RD1D = read_view[rsD];
    RD2D = read_view[rtD];
`ifdef WB_BYPASS_EN
    if (RSTn && write_req && (rtdW == rsD)) begin
      RD1D = ResultW;
    end
    if (RSTn && write_req && (rtdW == rtD)) begin
      RD2D = ResultW;
    end
`endif
  end

  assign WBCount = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized self-checking bench for wb_regfile.
// Two instances share all inputs. One uses the default 16-bit counter and
// one uses a 4-bit counter, so saturation is exercised alongside normal
// operation. A behavioural model (array of 32 words plus integer counters)
// predicts every output.
module tb_wb_regfile;

  logic        CLK;
  logic        RSTn;
  logic        RFWEW;
  logic        MtoRFSelW;
  logic [31:0] DMOutW;
  logic [31:0] ALUOutW;
  logic [4:0]  rtdW;
  logic [4:0]  rsD;
  logic [4:0]  rtD;
  logic [31:0] rd1A, rd2A, resA;
  logic [31:0] rd1B, rd2B, resB;
  logic [15:0] cntA;
  logic [3:0]  cntB;

  int errors = 0;
  int checks = 0;

  logic [31:0] modelRegs [32];
  int          modelCntA;
  int          modelCntB;
  bit          modelValid = 0;

  wb_regfile #(.CNT_W(16)) dutA (
    .CLK(CLK), .RSTn(RSTn), .RFWEW(RFWEW), .MtoRFSelW(MtoRFSelW),
    .DMOutW(DMOutW), .ALUOutW(ALUOutW), .rtdW(rtdW), .rsD(rsD), .rtD(rtD),
    .RD1D(rd1A), .RD2D(rd2A), .ResultW(resA), .WBCount(cntA)
  );

  wb_regfile #(.CNT_W(4)) dutB (
    .CLK(CLK), .RSTn(RSTn), .RFWEW(RFWEW), .MtoRFSelW(MtoRFSelW),
    .DMOutW(DMOutW), .ALUOutW(ALUOutW), .rtdW(rtdW), .rsD(rsD), .rtD(rtD),
    .RD1D(rd1B), .RD2D(rd2B), .ResultW(resB), .WBCount(cntB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs (blocking) shortly after the falling edge, then let the
  // combinational outputs settle.
  task automatic applyStimulus(input logic rst_n, input logic we,
                               input logic sel, input logic [31:0] dm,
                               input logic [31:0] alu, input logic [4:0] rtd,
                               input logic [4:0] rs, input logic [4:0] rt);
    RSTn      = rst_n;
    RFWEW     = we;
    MtoRFSelW = sel;
    DMOutW    = dm;
    ALUOutW   = alu;
    rtdW      = rtd;
    rsD       = rs;
    rtD       = rt;
    #1;
  endtask

  function automatic logic [31:0] modelResult();
    return MtoRFSelW ? DMOutW : ALUOutW;
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (RSTn && RFWEW && rtdW == idx) return modelResult();
`endif
    return modelRegs[idx];
  endfunction

  // Compare every DUT output against the model for the current inputs.
  task automatic checkModel();
    checkOutput("ResultW", resA, modelResult());
    checkOutput("ResultW_c4", resB, modelResult());
    if (modelValid) begin
      checkOutput("RD1D", rd1A, modelRead(rsD));
      checkOutput("RD2D", rd2A, modelRead(rtD));
      checkOutput("RD1D_c4", rd1B, modelRead(rsD));
      checkOutput("RD2D_c4", rd2B, modelRead(rtD));
      checkOutput("WBCount", {16'd0, cntA}, 32'(modelCntA));
      checkOutput("WBCount_c4", {28'd0, cntB}, 32'(modelCntB));
    end
  endtask

  // Advance one clock and update the model from the sampled inputs.
  task automatic stepClock();
    @(posedge CLK);
    if (!RSTn) begin
      for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
      modelCntA  = 0;
      modelCntB  = 0;
      modelValid = 1;
    end else if (RFWEW && rtdW != 5'd0) begin
      modelRegs[rtdW] = modelResult();
      if (modelCntA < 65535) modelCntA++;
      if (modelCntB < 15) modelCntB++;
    end
    @(negedge CLK);
  endtask

  task automatic cycle(input logic rst_n, input logic we, input logic sel,
                       input logic [31:0] dm, input logic [31:0] alu,
                       input logic [4:0] rtd, input logic [4:0] rs,
                       input logic [4:0] rt);
    applyStimulus(rst_n, we, sel, dm, alu, rtd, rs, rt);
    checkModel();
    stepClock();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
    modelCntA = 0;
    modelCntB = 0;
    @(negedge CLK);

    // Initial reset. Outputs are unknown before the first clearing edge.
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd9, 5'd31);
    checkOutput("rst_rd1", rd1A, 32'd0);
    checkOutput("rst_rd2", rd2A, 32'd0);
    checkOutput("rst_cnt", {16'd0, cntA}, 32'd0);
    checkModel();

    // ALU result write to x5, then read it back.
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_00A5, 5'd5, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);
    checkOutput("alu_wr_x5", rd1A, 32'h0000_00A5);
    checkOutput("alu_wr_cnt", {16'd0, cntA}, 32'd1);
    checkModel();
    stepClock();

    // Memory-data select writes x31.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1, 5'd31, 5'd0, 5'd0);
    checkOutput("mem_sel_res", resA, 32'hDEAD_BEEF);
    checkModel();
    stepClock();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd31, 5'd31);
    checkOutput("mem_wr_x31", rd2A, 32'hDEAD_BEEF);
    checkModel();
    stepClock();

    // Write to x0 is ignored.
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_read", rd1A, 32'd0);
    checkOutput("x0_cnt", {16'd0, cntA}, 32'd2);
    checkModel();
    stepClock();

    // Same-cycle read of a register being written.
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 5'd7, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h1234, 5'd7, 5'd7, 5'd7);
`ifdef WB_BYPASS_EN
    checkOutput("same_rd1", rd1A, 32'h1234);
    checkOutput("same_rd2", rd2A, 32'h1234);
`else
    checkOutput("same_rd1", rd1A, 32'h55);
    checkOutput("same_rd2", rd2A, 32'h55);
`endif
    checkModel();
    stepClock();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd7, 5'd7);
    checkOutput("next_rd1", rd1A, 32'h1234);
    checkModel();
    stepClock();

    // Reset with a write pending: write dropped, everything cleared.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h9, 5'd3, 5'd7, 5'd31);
    checkOutput("rst_hold_rd1", rd1A, 32'h1234);
    checkModel();
    stepClock();
    for (int i = 0; i < 32; i += 2) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'(i), 5'(i + 1));
      checkOutput("post_rst_rd1", rd1A, 32'd0);
      checkOutput("post_rst_rd2", rd2A, 32'd0);
      checkModel();
      stepClock();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd0);
    checkOutput("post_rst_cnt", {16'd0, cntA}, 32'd0);
    checkModel();
    stepClock();

    // Saturation of the 4-bit counter: 20 writes to x1.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'(i + 100), 5'd1, 5'd1, 5'd2);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd1, 5'd0);
    checkOutput("sat_c4", {28'd0, cntB}, 32'd15);
    checkOutput("sat_c16", {16'd0, cntA}, 32'd20);
    checkOutput("sat_x1", rd1A, 32'd119);
    checkModel();
    stepClock();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 49) != 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom, $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
